// File: rtl/pl_reset_seq.sv
// ---------------------------------------------------------------------------
// pl_reset_seq
//
// Reset sequencer running on pl_clk0. It waits for the clock sources to lock,
// debounces the combined lock status, then releases the mclk-domain reset
// request first and the clk-domain reset request a fixed gap later. If a lock
// is lost after release, both requests are re-asserted, the loss is counted
// and the sequence starts again from the TCXO wait.
//
// Ports:
//   clk           pl_clk0
//   reset         asynchronous active-high reset (inverted pl_reset_n)
//   sys_reset     synchronous software restart request (level)
//   tcxo_req      1 = TCXO PLL lock is required, 0 = tcxo_locked is ignored
//   tcxo_locked   TCXO PLL lock (already synchronised)
//   clk_locked    clk ClkWiz lock (already synchronised)
//   mclk_locked   mclk ClkWiz lock (already synchronised)
//   clear_status  single-cycle pulse clearing timeout and loss_count
//   reset_req     clk-domain reset request, high = hold in reset
//   mreset_req    mclk-domain reset request, high = hold in reset
//   ready         high only in RUN
//   state         current state encoding
//   timeout       sticky flag: a WAIT state ran for TIMEOUT_CYCLES
//   loss_count    saturating count of lock losses after release
// ---------------------------------------------------------------------------
module pl_reset_seq #(
    parameter int STABLE_CYCLES  = 1000,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sys_reset,
    input  logic       tcxo_req,
    input  logic       tcxo_locked,
    input  logic       clk_locked,
    input  logic       mclk_locked,
    input  logic       clear_status,
    output logic       reset_req,
    output logic       mreset_req,
    output logic       ready,
    output logic [2:0] state,
    output logic       timeout,
    output logic [7:0] loss_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TCXO = 3'd1;
    localparam logic [2:0] S_WAIT_CLK  = 3'd2;
    localparam logic [2:0] S_STABLE    = 3'd3;
    localparam logic [2:0] S_REL_M     = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_FAULT     = 3'd6;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic             reset_req_reg, reset_req_next;
    logic             mreset_req_reg, mreset_req_next;
    logic             ready_reg, ready_next;
    logic             timeout_reg, timeout_next;
    logic [7:0]       loss_count_reg, loss_count_next;

    logic             tcxo_ok;
    logic             all_ok;
    logic [CNT_W-1:0] counter_inc;
    logic             timeout_event;
    logic             loss_event;

    assign tcxo_ok     = tcxo_locked | ~tcxo_req;
    assign all_ok      = tcxo_ok & clk_locked & mclk_locked;
    // Shared counter never wraps, so a long stall cannot re-arm the compare.
    assign counter_inc = (counter_reg == CNT_MAX) ? counter_reg
                                                  : counter_reg + CNT_W'(1);

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            counter_reg    <= '0;
            reset_req_reg  <= 1'b1;
            mreset_req_reg <= 1'b1;
            ready_reg      <= 1'b0;
            timeout_reg    <= 1'b0;
            loss_count_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            counter_reg    <= counter_next;
            reset_req_reg  <= reset_req_next;
            mreset_req_reg <= mreset_req_next;
            ready_reg      <= ready_next;
            timeout_reg    <= timeout_next;
            loss_count_reg <= loss_count_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_next    = state_reg;
        counter_next  = counter_reg;
        timeout_event = 1'b0;
        loss_event    = 1'b0;
        if (sys_reset) begin
            state_next   = S_IDLE;
            counter_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next   = S_WAIT_TCXO;
                    counter_next = '0;
                end
                S_WAIT_TCXO: begin
                    if (tcxo_ok) begin
                        state_next   = S_WAIT_CLK;
                        counter_next = '0;
                    end else begin
                        counter_next  = counter_inc;
                        timeout_event = (counter_reg == TIMEOUT_LAST);
                    end
                end
                S_WAIT_CLK: begin
                    if (all_ok) begin
                        state_next   = S_STABLE;
                        counter_next = '0;
                    end else begin
                        counter_next  = counter_inc;
                        timeout_event = (counter_reg == TIMEOUT_LAST);
                    end
                end
                S_STABLE: begin
                    // Drops before release restart the debounce; not counted as losses.
                    if (!tcxo_ok) begin
                        state_next   = S_WAIT_TCXO;
                        counter_next = '0;
                    end else if (!all_ok) begin
                        state_next   = S_WAIT_CLK;
                        counter_next = '0;
                    end else if (counter_reg == STABLE_LAST) begin
                        state_next   = S_REL_M;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_inc;
                    end
                end
                S_REL_M: begin
                    if (!all_ok) begin
                        state_next   = S_FAULT;
                        counter_next = '0;
                        loss_event   = 1'b1;
                    end else if (counter_reg == GAP_LAST) begin
                        state_next   = S_RUN;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_inc;
                    end
                end
                S_RUN: begin
                    if (!all_ok) begin
                        state_next   = S_FAULT;
                        counter_next = '0;
                        loss_event   = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_next   = S_WAIT_TCXO;
                    counter_next = '0;
                end
                default: begin
                    state_next   = S_IDLE;
                    counter_next = '0;
                end
            endcase
        end
    end

    // Registered outputs are derived from the state being entered, so they
    // change on the same edge as the transition.
    always_comb begin
        reset_req_next  = (state_next != S_RUN);
        mreset_req_next = !((state_next == S_REL_M) || (state_next == S_RUN));
        ready_next      = (state_next == S_RUN);

        // Set/increment beats a coincident clear.
        if (timeout_event) begin
            timeout_next = 1'b1;
        end else if (clear_status) begin
            timeout_next = 1'b0;
        end else begin
            timeout_next = timeout_reg;
        end

        if (loss_event) begin
            loss_count_next = (loss_count_reg == 8'hFF) ? loss_count_reg
                                                        : loss_count_reg + 8'd1;
        end else if (clear_status) begin
            loss_count_next = 8'd0;
        end else begin
            loss_count_next = loss_count_reg;
        end
    end

    assign state      = state_reg;
    assign reset_req  = reset_req_reg;
    assign mreset_req = mreset_req_reg;
    assign ready      = ready_reg;
    assign timeout    = timeout_reg;
    assign loss_count = loss_count_reg;

endmodule

// File: tb/tb_pl_reset_seq.sv
module tb_pl_reset_seq;

    localparam int STABLE = 8;
    localparam int GAP    = 4;
    localparam int TMO    = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       sys_reset;
    logic       tcxo_req;
    logic       tcxo_locked;
    logic       clk_locked;
    logic       mclk_locked;
    logic       clear_status;
    logic       reset_req;
    logic       mreset_req;
    logic       ready;
    logic [2:0] state;
    logic       timeout;
    logic [7:0] loss_count;

    pl_reset_seq #(
        .STABLE_CYCLES  (STABLE),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sys_reset    (sys_reset),
        .tcxo_req     (tcxo_req),
        .tcxo_locked  (tcxo_locked),
        .clk_locked   (clk_locked),
        .mclk_locked  (mclk_locked),
        .clear_status (clear_status),
        .reset_req    (reset_req),
        .mreset_req   (mreset_req),
        .ready        (ready),
        .state        (state),
        .timeout      (timeout),
        .loss_count   (loss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total_cnt  = 0;
    int   passed_cnt = 0;

    task automatic push(input string tag, input logic [7:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic pop_check(input logic [7:0] obs);
        exp_t item;
        total_cnt++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0d required an expectation", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.exp) begin
                passed_cnt++;
            end else begin
                $error("FAIL %s: observed %0d required %0d", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_outs(input string tag, input logic [2:0] st, input logic rr,
                             input logic mr, input logic rdy);
        push({tag, "/state"}, {5'd0, st});
        push({tag, "/reset_req"}, {7'd0, rr});
        push({tag, "/mreset_req"}, {7'd0, mr});
        push({tag, "/ready"}, {7'd0, rdy});
    endtask

    task automatic pop_outs();
        pop_check({5'd0, state});
        pop_check({7'd0, reset_req});
        pop_check({7'd0, mreset_req});
        pop_check({7'd0, ready});
    endtask

    // One clock: expectations queued before the edge, compared after it.
    task automatic step(input string tag, input logic [2:0] st, input logic rr,
                        input logic mr, input logic rdy);
        push_outs(tag, st, rr, mr, rdy);
        tick();
        pop_outs();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] e);
        push(tag, e);
        pop_check(obs);
    endtask

    // Called on the cycle STABLE has just been entered with all locks held.
    task automatic check_release(input string tag);
        for (int i = 1; i < STABLE; i++) step({tag, ":stable"}, 3'd3, 1'b1, 1'b1, 1'b0);
        step({tag, ":rel_m"}, 3'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < GAP; i++) step({tag, ":gap"}, 3'd4, 1'b1, 1'b0, 1'b0);
        step({tag, ":run"}, 3'd5, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int limit);
        int n;
        n = 0;
        push(tag, {5'd0, s});
        while (state !== s && n < limit) begin
            tick();
            n++;
        end
        pop_check({5'd0, state});
    endtask

    task automatic restart(input string tag);
        sys_reset = 1'b1;
        step({tag, ":sysrst"}, 3'd0, 1'b1, 1'b1, 1'b0);
        sys_reset = 1'b0;
    endtask

    // Request ordering must hold on every cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            total_cnt++;
            assert (!(!reset_req && mreset_req) && !(reset_req && !mreset_req && state != 3'd4)) begin
                passed_cnt++;
            end else begin
                $error("FAIL invariant: observed state=%0d reset_req=%0d mreset_req=%0d required ordered requests",
                       state, reset_req, mreset_req);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        sys_reset    = 1'b0;
        tcxo_req     = 1'b1;
        tcxo_locked  = 1'b1;
        clk_locked   = 1'b1;
        mclk_locked  = 1'b1;
        clear_status = 1'b0;

        // Reset values
        tick();
        tick();
        push_outs("reset", 3'd0, 1'b1, 1'b1, 1'b0);
        pop_outs();
        chk("reset/timeout", {7'd0, timeout}, 8'd0);
        chk("reset/loss", loss_count, 8'd0);

        // Bring-up with all locks present
        reset = 1'b0;
        step("up:wait_tcxo", 3'd1, 1'b1, 1'b1, 1'b0);
        step("up:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        step("up:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        check_release("up");
        chk("up/loss", loss_count, 8'd0);
        chk("up/timeout", {7'd0, timeout}, 8'd0);

        // One-cycle clk lock loss in RUN
        clk_locked = 1'b0;
        step("loss1:fault", 3'd6, 1'b1, 1'b1, 1'b0);
        chk("loss1/loss", loss_count, 8'd1);
        clk_locked = 1'b1;
        step("loss1:wait_tcxo", 3'd1, 1'b1, 1'b1, 1'b0);
        step("loss1:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        step("loss1:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        check_release("loss1");

        // sys_reset in RUN and in REL_M: no loss counted
        restart("sr_run");
        chk("sr_run/loss", loss_count, 8'd1);
        step("sr:wait_tcxo", 3'd1, 1'b1, 1'b1, 1'b0);
        step("sr:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        step("sr:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < STABLE; i++) step("sr:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        step("sr:rel_m", 3'd4, 1'b1, 1'b0, 1'b0);
        step("sr:rel_m2", 3'd4, 1'b1, 1'b0, 1'b0);
        restart("sr_relm");
        chk("sr_relm/loss", loss_count, 8'd1);

        // TCXO lock timeout
        tcxo_locked = 1'b0;
        step("tmo:wait_tcxo", 3'd1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < TMO; i++) tick();
        chk("tmo/before", {7'd0, timeout}, 8'd0);
        step("tmo:hold", 3'd1, 1'b1, 1'b1, 1'b0);
        chk("tmo/set", {7'd0, timeout}, 8'd1);
        tcxo_locked = 1'b1;
        step("tmo:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        step("tmo:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        check_release("tmo");
        chk("tmo/sticky", {7'd0, timeout}, 8'd1);
        clear_status = 1'b1;
        step("clr:run", 3'd5, 1'b0, 1'b0, 1'b1);
        clear_status = 1'b0;
        chk("clr/timeout", {7'd0, timeout}, 8'd0);
        chk("clr/loss", loss_count, 8'd0);

        // TCXO not required: its lock is ignored
        restart("notcxo");
        tcxo_req    = 1'b0;
        tcxo_locked = 1'b0;
        step("notcxo:wait_tcxo", 3'd1, 1'b1, 1'b1, 1'b0);
        step("notcxo:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        step("notcxo:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        check_release("notcxo");
        for (int i = 0; i < 6; i++) begin
            tcxo_locked = ~tcxo_locked;
            step("notcxo:toggle", 3'd5, 1'b0, 1'b0, 1'b1);
        end
        chk("notcxo/loss", loss_count, 8'd0);
        tcxo_req    = 1'b1;
        tcxo_locked = 1'b1;

        // mclk glitch during debounce at counter=5
        restart("glitch");
        step("glitch:wait_tcxo", 3'd1, 1'b1, 1'b1, 1'b0);
        step("glitch:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        step("glitch:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("glitch:count", 3'd3, 1'b1, 1'b1, 1'b0);
        mclk_locked = 1'b0;
        step("glitch:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        mclk_locked = 1'b1;
        step("glitch:restable", 3'd3, 1'b1, 1'b1, 1'b0);
        check_release("glitch");
        chk("glitch/loss", loss_count, 8'd0);

        // 260 losses: loss_count saturates at 255
        for (int i = 1; i <= 260; i++) begin
            clk_locked = 1'b0;
            step("sat:fault", 3'd6, 1'b1, 1'b1, 1'b0);
            chk("sat/loss", loss_count, (i > 255) ? 8'd255 : 8'(i));
            clk_locked = 1'b1;
            wait_state("sat:rerun", 3'd5, 40);
        end

        // Asynchronous reset mid-debounce
        restart("async");
        step("async:wait_tcxo", 3'd1, 1'b1, 1'b1, 1'b0);
        step("async:wait_clk", 3'd2, 1'b1, 1'b1, 1'b0);
        step("async:stable", 3'd3, 1'b1, 1'b1, 1'b0);
        step("async:stable2", 3'd3, 1'b1, 1'b1, 1'b0);
        #2;
        push_outs("async", 3'd0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        pop_outs();
        chk("async/loss", loss_count, 8'd0);
        chk("async/timeout", {7'd0, timeout}, 8'd0);
        tick();
        reset = 1'b0;
        step("async:restart", 3'd1, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
